// File: rtl/rv32i_types.sv
// rv32i_types: shared fetch-stage types (state encoding and the {inst, pc} packet).
package rv32i_types;
    typedef enum logic {FETCH_IDLE, FETCH_REQ} fetch_state_t;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_pkt_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry fetch_pkt_t holding buffer with valid/ready on both sides and a
// synchronous clear. Instantiated by fetch_stage only when FETCH_PREFETCH_EN is defined.
module fetch_skid_buf
    import rv32i_types::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       in_valid,
    output logic       in_ready,
    input  fetch_pkt_t in_pkt,
    output logic       out_valid,
    input  logic       out_ready,
    output fetch_pkt_t out_pkt
);
    logic       valid_q, valid_d;
    fetch_pkt_t pkt_q, pkt_d;
    always_comb begin
        valid_d = clear ? 1'b0 : (in_valid && in_ready) ? 1'b1 : out_ready ? 1'b0 : valid_q;
        pkt_d   = (in_valid && in_ready) ? in_pkt : pkt_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end
    assign in_ready  = !valid_q;
    assign out_valid = valid_q;
    assign out_pkt   = pkt_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and single-outstanding-request instruction fetch with redirect handling.
// FETCH_PREFETCH_EN adds a one-entry skid so the next request can overlap a stalled output.
module fetch_stage
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_inst,
    output logic [31:0] fetch_pc,
    input  logic        flush,
    input  logic [31:0] redirect_pc
);
    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d, req_addr_q, req_addr_d;
    logic         drop_q, drop_d, out_valid_q, out_valid_d;
    fetch_pkt_t   out_q, out_d, resp_pkt, skid_pkt;
    logic         xfer, resp_ok, slot_free, skid_valid;
    // A flush cancels any same-cycle handshake, so it never counts as a transfer.
    assign xfer     = out_valid_q && fetch_ready && !flush;
    assign resp_ok  = state_q == FETCH_REQ && imem_resp && !drop_q && !flush;
    assign resp_pkt = '{inst: imem_rdata, pc: req_addr_q};
`ifdef FETCH_PREFETCH_EN
    logic skid_ready;
    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .in_valid  (resp_ok && out_valid_q && !xfer),
        .in_ready  (skid_ready),
        .in_pkt    (resp_pkt),
        .out_valid (skid_valid),
        .out_ready (xfer),
        .out_pkt   (skid_pkt)
    );
    assign slot_free = skid_ready;
`else
    assign skid_valid = 1'b0;
    assign skid_pkt   = '0;
    assign slot_free  = !out_valid_q || xfer;
`endif
    always_comb begin
        state_d     = state_q;
        pc_d        = flush ? (redirect_pc & ~32'h3) : pc_q;
        req_addr_d  = req_addr_q;
        drop_d      = drop_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (state_q == FETCH_IDLE) begin
            if (!flush && slot_free) begin
                state_d    = FETCH_REQ;
                req_addr_d = pc_q;
            end
        end else if (imem_resp) begin
            state_d = FETCH_IDLE;
            drop_d  = 1'b0;
            if (resp_ok)
                pc_d = pc_q + 32'd4;
        end else if (flush) begin
            drop_d = 1'b1;
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (xfer) begin
            out_valid_d = skid_valid || resp_ok;
            out_d       = skid_valid ? skid_pkt : resp_ok ? resp_pkt : out_q;
        end else if (!out_valid_q && resp_ok) begin
            out_valid_d = 1'b1;
            out_d       = resp_pkt;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= FETCH_IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            drop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end
    assign imem_addr   = req_addr_q;
    assign imem_rmask  = (state_q == FETCH_REQ) ? 4'hF : 4'h0;
    assign fetch_valid = out_valid_q;
    assign fetch_inst  = out_q.inst;
    assign fetch_pc    = out_q.pc;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed, table-driven bench for fetch_stage; the bench plays the imem itself.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst, imem_resp, fetch_ready, flush;
    logic [31:0] imem_rdata, redirect_pc, imem_addr, fetch_inst, fetch_pc;
    logic [3:0]  imem_rmask;
    logic        fetch_valid;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rmask  (imem_rmask),
        .imem_rdata  (imem_rdata),
        .imem_resp   (imem_resp),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_inst  (fetch_inst),
        .fetch_pc    (fetch_pc),
        .flush       (flush),
        .redirect_pc (redirect_pc)
    );
    typedef struct {
        logic        rst, resp, ready, flush;
        logic [31:0] rdata, redir;
        logic [31:0] e_addr;
        logic [3:0]  e_mask;
        logic        e_valid;
        logic [31:0] e_inst, e_pc;
    } vec_t;
    localparam logic [31:0] B = 32'h1eceb000;
    vec_t vecs[26];
    function automatic vec_t mk(logic r, logic rs, logic [31:0] rd, logic rdy, logic fl,
                                logic [31:0] rp, logic [31:0] a, logic [3:0] m, logic v,
                                logic [31:0] ins, logic [31:0] p);
        vec_t t;
        t.rst = r; t.resp = rs; t.rdata = rd; t.ready = rdy; t.flush = fl; t.redir = rp;
        t.e_addr = a; t.e_mask = m; t.e_valid = v; t.e_inst = ins; t.e_pc = p;
        return t;
    endfunction
    task automatic drive(input logic r, input logic rs, input logic [31:0] rd, input logic rdy,
                         input logic fl, input logic [31:0] rp);
        @(negedge clk);
        rst = r; imem_resp = rs; imem_rdata = rd; fetch_ready = rdy; flush = fl; redirect_pc = rp;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask
    initial begin
        rst = 1'b0; imem_resp = 1'b0; imem_rdata = '0; fetch_ready = 1'b0; flush = 1'b0; redirect_pc = '0;
        // reset, then three sequential fetches with a 1-cycle memory
        vecs[0]  = mk(0, 0, 0,            0, 0, 0,            B,            4'h0, 0, 0,            0);
        vecs[1]  = mk(1, 0, 0,            1, 0, 0,            B,            4'hF, 0, 0,            0);
        vecs[2]  = mk(1, 1, 32'h11110013, 1, 0, 0,            B,            4'h0, 1, 32'h11110013, B);
        vecs[3]  = mk(1, 0, 0,            1, 0, 0,            B + 4,        4'hF, 0, 0,            0);
        vecs[4]  = mk(1, 1, 32'h22220013, 1, 0, 0,            B + 4,        4'h0, 1, 32'h22220013, B + 4);
        vecs[5]  = mk(1, 0, 0,            1, 0, 0,            B + 8,        4'hF, 0, 0,            0);
        vecs[6]  = mk(1, 1, 32'h33330013, 1, 0, 0,            B + 8,        4'h0, 1, 32'h33330013, B + 8);
        vecs[7]  = mk(1, 0, 0,            1, 0, 0,            B + 12,       4'hF, 0, 0,            0);
        // flush while REQ, response three cycles later is dropped
        vecs[8]  = mk(1, 0, 0,            1, 1, 32'h1eceb103, B + 12,       4'hF, 0, 0,            0);
        vecs[9]  = mk(1, 0, 0,            1, 0, 0,            B + 12,       4'hF, 0, 0,            0);
        vecs[10] = mk(1, 0, 0,            1, 0, 0,            B + 12,       4'hF, 0, 0,            0);
        vecs[11] = mk(1, 1, 32'hdeaddead, 1, 0, 0,            B + 12,       4'h0, 0, 0,            0);
        vecs[12] = mk(1, 0, 0,            1, 0, 0,            32'h1eceb100, 4'hF, 0, 0,            0);
        // flush in the same cycle as the response
        vecs[13] = mk(1, 1, 32'h0bad0bad, 1, 1, 32'h1eceb200, 32'h1eceb100, 4'h0, 0, 0,            0);
        vecs[14] = mk(1, 0, 0,            1, 0, 0,            32'h1eceb200, 4'hF, 0, 0,            0);
        // redirect to the top word, then wrap the PC
        vecs[15] = mk(1, 0, 0,            1, 1, 32'hffffffff, 32'h1eceb200, 4'hF, 0, 0,            0);
        vecs[16] = mk(1, 1, 32'hdeaddead, 1, 0, 0,            32'h1eceb200, 4'h0, 0, 0,            0);
        vecs[17] = mk(1, 0, 0,            0, 0, 0,            32'hfffffffc, 4'hF, 0, 0,            0);
        vecs[18] = mk(1, 1, 32'h55550013, 0, 0, 0,            32'hfffffffc, 4'h0, 1, 32'h55550013, 32'hfffffffc);
        vecs[19] = mk(1, 0, 0,            1, 0, 0,            32'h00000000, 4'hF, 0, 0,            0);
        // reset mid-request; stray response after release is ignored
        vecs[20] = mk(0, 0, 0,            1, 0, 0,            B,            4'h0, 0, 0,            0);
        vecs[21] = mk(1, 1, 32'hbadbad00, 1, 0, 0,            B,            4'hF, 0, 0,            0);
        vecs[22] = mk(1, 0, 0,            1, 0, 0,            B,            4'hF, 0, 0,            0);
        vecs[23] = mk(1, 1, 32'h66660013, 0, 0, 0,            B,            4'h0, 1, 32'h66660013, B);
        // flush together with ready kills the held output
        vecs[24] = mk(1, 0, 0,            1, 1, 32'h1eceb300, B,            4'h0, 0, 0,            0);
        vecs[25] = mk(1, 0, 0,            1, 0, 0,            32'h1eceb300, 4'hF, 0, 0,            0);
        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].rst, vecs[i].resp, vecs[i].rdata, vecs[i].ready, vecs[i].flush, vecs[i].redir);
            chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d imem_rmask", i), {28'h0, imem_rmask}, {28'h0, vecs[i].e_mask});
            chk($sformatf("v%0d fetch_valid", i), {31'h0, fetch_valid}, {31'h0, vecs[i].e_valid});
            if (vecs[i].e_valid || !vecs[i].rst) begin
                chk($sformatf("v%0d fetch_inst", i), fetch_inst, vecs[i].e_inst);
                chk($sformatf("v%0d fetch_pc", i), fetch_pc, vecs[i].e_pc);
            end
        end
        // stalled consumer: output held for 10 cycles
        drive(1, 1, 32'h77770013, 0, 0, 0);
        chk("stall first valid", {31'h0, fetch_valid}, 32'h1);
        chk("stall first inst", fetch_inst, 32'h77770013);
        chk("stall first pc", fetch_pc, 32'h1eceb300);
        for (int c = 0; c < 10; c++) begin
`ifdef FETCH_PREFETCH_EN
            drive(1, c == 1, 32'h88880013, 0, 0, 0);
            chk($sformatf("stall%0d rmask", c), {28'h0, imem_rmask}, (c == 0) ? 32'hF : 32'h0);
            if (c == 0)
                chk("stall prefetch addr", imem_addr, 32'h1eceb304);
`else
            drive(1, 0, 0, 0, 0, 0);
            chk($sformatf("stall%0d rmask", c), {28'h0, imem_rmask}, 32'h0);
`endif
            chk($sformatf("stall%0d valid", c), {31'h0, fetch_valid}, 32'h1);
            chk($sformatf("stall%0d inst", c), fetch_inst, 32'h77770013);
            chk($sformatf("stall%0d pc", c), fetch_pc, 32'h1eceb300);
        end
        drive(1, 0, 0, 1, 0, 0);
`ifdef FETCH_PREFETCH_EN
        chk("drain valid", {31'h0, fetch_valid}, 32'h1);
        chk("drain inst", fetch_inst, 32'h88880013);
        chk("drain pc", fetch_pc, 32'h1eceb304);
        chk("drain rmask", {28'h0, imem_rmask}, 32'h0);
        drive(1, 0, 0, 1, 0, 0);
        chk("after drain valid", {31'h0, fetch_valid}, 32'h0);
        chk("after drain addr", imem_addr, 32'h1eceb308);
        chk("after drain rmask", {28'h0, imem_rmask}, 32'hF);
`else
        chk("release valid", {31'h0, fetch_valid}, 32'h0);
        chk("release addr", imem_addr, 32'h1eceb304);
        chk("release rmask", {28'h0, imem_rmask}, 32'hF);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
